// File: rtl/mem32_pkg.sv
// Shared types and helpers for the 32-bit memory load/store unit.
package mem32_pkg;

  // Bus word-address width (32K words).
  localparam int WA_W = 15;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B1   = 3'd1,
    B2   = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } lsu_st_e;

  // Access width in bytes.
  function automatic logic [2:0] size_bytes(input size_e sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // True when the access crosses into the next word.
  function automatic logic is_split(input logic [1:0] o, input logic [2:0] n);
    return ({2'b00, o} + {1'b0, n}) > 4'd4;
  endfunction

  // Byte lanes touched by beat 0 (first word) or beat 1 (following word).
  function automatic logic [3:0] lane_mask(input logic [1:0] o, input logic [2:0] n,
                                           input logic beat);
    logic [7:0] ones;
    logic [7:0] full;
    case (n)
      3'd1:    ones = 8'h01;
      3'd2:    ones = 8'h03;
      default: ones = 8'h0F;
    endcase
    full = ones << o;
    return beat ? full[7:4] : full[3:0];
  endfunction

endpackage

// File: rtl/mem32_lsu_if.sv
// 32-bit memory bus: word address, write data, byte mask, write enable, read data.
interface mb32_io;
  logic                          clk;
  logic [mem32_pkg::WA_W-1:0]    ai;
  logic [31:0]                   vi;
  logic [3:0]                    bmsk;
  logic                          we;
  logic [31:0]                   vo;

  modport master (output clk, output ai, output vi, output bmsk, output we, input vo);
  modport slave  (input clk, input ai, input vi, input bmsk, input we, output vo);
endinterface

// File: rtl/mem32_align.sv
// Byte-lane steering: store data shifted into lanes, load data extracted and extended.
module mem32_align
  import mem32_pkg::*;
(
  input  size_e       size,
  input  logic        sgn,
  input  logic [1:0]  ofs,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_lo,
  input  logic [31:0] rd_hi,
  output logic [31:0] st_lo,
  output logic [31:0] st_hi,
  output logic [31:0] ld_data
);

  logic [63:0] st_wide;
  logic [31:0] fld;

  // Store data spans two words: low half goes to beat 1, high half to beat 2.
  // Load field is {beat2, beat1} shifted down to lane 0, then extended.
  always_comb begin
    st_wide = {32'd0, wdata} << {ofs, 3'b000};
    st_lo   = st_wide[31:0];
    st_hi   = st_wide[63:32];
    fld     = 32'({rd_hi, rd_lo} >> {ofs, 3'b000});
    case (size)
      SZ_B:    ld_data = {{24{sgn & fld[7]}}, fld[7:0]};
      SZ_H:    ld_data = {{16{sgn & fld[15]}}, fld[15:0]};
      default: ld_data = fld;
    endcase
  end

endmodule

// File: rtl/mem32_lsu.sv
// Load/store unit: byte/half/word requests at any byte address onto the 32-bit
// word bus, splitting word-crossing accesses into two beats.
module mem32_lsu
  import mem32_pkg::*;
#(
  parameter int AW     = 17,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  mb32_io.master        b32_if
);

  lsu_st_e           st_q, st_d;
  logic              we_q, we_d;
  size_e             size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [WA_W-1:0]   ai_q, ai_d;
  logic [31:0]       vi_q, vi_d;
  logic [3:0]        bmsk_q, bmsk_d;
  logic              bwe_q, bwe_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [RD_LAT-1:0] pv_q, pv_d;
  logic [RD_LAT-1:0] pl_q, pl_d;
  logic [31:0]       hold_q, hold_d;
  logic [31:0]       res_q, res_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  logic              idle;
  size_e             req_sz;
  size_e             cur_size;
  logic              cur_sgn;
  logic [AW-1:0]     cur_addr;
  logic [31:0]       cur_wdata;
  logic [1:0]        ofs;
  logic [2:0]        nb;
  logic              split;
  logic [WA_W-1:0]   wa;
  logic              issue, issue_last;
  logic [31:0]       rd_lo;
  logic [31:0]       st_lo, st_hi, ld_data;

  // While idle, decode straight from the request so beat 1 can be registered
  // at the accept edge; afterwards use the latched request.
  always_comb begin
    idle      = (st_q == IDLE);
    req_sz    = (req_size == 2'd3) ? SZ_W : size_e'(req_size);
    cur_size  = idle ? req_sz     : size_q;
    cur_sgn   = idle ? req_signed : sgn_q;
    cur_addr  = idle ? req_addr   : addr_q;
    cur_wdata = idle ? req_wdata  : wdata_q;
    ofs       = cur_addr[1:0];
    wa        = cur_addr[AW-1:2];
    nb        = size_bytes(cur_size);
    split     = is_split(ofs, nb);
    rd_lo     = split ? hold_q : b32_if.vo;
  end

  mem32_align u_align (
    .size    (cur_size),
    .sgn     (cur_sgn),
    .ofs     (ofs),
    .wdata   (cur_wdata),
    .rd_lo   (rd_lo),
    .rd_hi   (b32_if.vo),
    .st_lo   (st_lo),
    .st_hi   (st_hi),
    .ld_data (ld_data)
  );

  // Read-return tracker: one stage per cycle of bus read latency, tagging
  // whether the returning word is the final beat of the load.
  always_comb begin
    pv_d[0] = issue;
    pl_d[0] = issue_last;
    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pl_d[i] = pl_q[i-1];
    end
  end

  // Next-state, bus beat generation, read capture and response.
  always_comb begin
    st_d        = st_q;
    we_d        = we_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ai_d        = ai_q;
    vi_d        = vi_q;
    bmsk_d      = 4'h0;
    bwe_d       = 1'b0;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    res_d       = res_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    issue       = 1'b0;
    issue_last  = 1'b0;

    // Returning read data: first beat of a split load parks in hold, the
    // final beat is assembled immediately.
    if (pv_q[RD_LAT-1]) begin
      if (pl_q[RD_LAT-1]) res_d = ld_data;
      else                hold_d = b32_if.vo;
    end

    case (st_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_sz;
          sgn_d   = req_signed;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          ai_d    = wa;
          if (req_we) begin
            vi_d   = st_lo;
            bmsk_d = lane_mask(ofs, nb, 1'b0);
            bwe_d  = 1'b1;
          end else begin
            bmsk_d = 4'hF;
          end
          st_d = B1;
        end
      end
      B1: begin
        issue      = !we_q;
        issue_last = !split;
        if (split) begin
          ai_d = wa + 1'b1;
          if (we_q) begin
            vi_d   = st_hi;
            bmsk_d = lane_mask(ofs, nb, 1'b1);
            bwe_d  = 1'b1;
          end else begin
            bmsk_d = 4'hF;
          end
          st_d = B2;
        end else begin
          st_d  = we_q ? DONE : WAIT;
          cnt_d = 2'(RD_LAT - 1);
        end
      end
      B2: begin
        issue      = !we_q;
        issue_last = 1'b1;
        st_d       = we_q ? DONE : WAIT;
        cnt_d      = 2'(RD_LAT - 1);
      end
      WAIT: begin
        if (cnt_q == 2'd0) st_d = DONE;
        else               cnt_d = cnt_q - 2'd1;
      end
      DONE: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = we_q ? 32'd0 : res_q;
        st_d        = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      we_q        <= 1'b0;
      size_q      <= SZ_B;
      sgn_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ai_q        <= '0;
      vi_q        <= '0;
      bmsk_q      <= '0;
      bwe_q       <= 1'b0;
      cnt_q       <= '0;
      pv_q        <= '0;
      pl_q        <= '0;
      hold_q      <= '0;
      res_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      st_q        <= st_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ai_q        <= ai_d;
      vi_q        <= vi_d;
      bmsk_q      <= bmsk_d;
      bwe_q       <= bwe_d;
      cnt_q       <= cnt_d;
      pv_q        <= pv_d;
      pl_q        <= pl_d;
      hold_q      <= hold_d;
      res_q       <= res_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready   = idle;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign b32_if.clk  = clk;
  assign b32_if.ai   = ai_q;
  assign b32_if.vi   = vi_q;
  assign b32_if.bmsk = bmsk_q;
  assign b32_if.we   = bwe_q;

endmodule

// File: tb/tb_mem32_lsu.sv
// Directed bench for mem32_lsu: instance 0 uses RD_LAT=1, instance 1 RD_LAT=2,
// each on its own bus with a word-memory model.
module tb_mem32_lsu;
  import mem32_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid  [2];
  logic        req_we     [2];
  logic [1:0]  req_size   [2];
  logic        req_signed [2];
  logic [16:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        req_ready  [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_rdata  [2];

  logic [1:0][14:0] obs_ai;
  logic [1:0][31:0] obs_vi;
  logic [1:0][3:0]  obs_bmsk;
  logic [1:0]       obs_we;

  mb32_io bus [2] ();

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mem32_lsu #(.AW(17), .RD_LAT(gi + 1)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid[gi]),
      .req_ready  (req_ready[gi]),
      .req_we     (req_we[gi]),
      .req_size   (req_size[gi]),
      .req_signed (req_signed[gi]),
      .req_addr   (req_addr[gi]),
      .req_wdata  (req_wdata[gi]),
      .rsp_valid  (rsp_valid[gi]),
      .rsp_rdata  (rsp_rdata[gi]),
      .b32_if     (bus[gi])
    );

    logic [31:0] mem [0:32767];
    logic [31:0] rd1, rd2, merged;

    always_comb begin
      merged = mem[bus[gi].ai];
      for (int b = 0; b < 4; b++)
        if (bus[gi].bmsk[b]) merged[8*b +: 8] = bus[gi].vi[8*b +: 8];
    end

    always_ff @(posedge clk) begin
      if (bus[gi].we) mem[bus[gi].ai] <= merged;
      rd1 <= mem[bus[gi].ai];
      rd2 <= rd1;
    end

    assign bus[gi].vo    = (gi == 0) ? rd1 : rd2;
    assign obs_ai[gi]    = bus[gi].ai;
    assign obs_vi[gi]    = bus[gi].vi;
    assign obs_bmsk[gi]  = bus[gi].bmsk;
    assign obs_we[gi]    = bus[gi].we;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [31:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request, push its expected response, return at the negedge of T+1.
  task automatic issue(input int d, input bit we, input logic [1:0] sz, input bit sg,
                       input logic [16:0] a, input logic [31:0] wd, input logic [31:0] exp_rsp);
    @(negedge clk);
    chk("ready_before_issue", 32'(req_ready[d]), 32'd1);
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_size[d]   = sz;
    req_signed[d] = sg;
    req_addr[d]   = a;
    req_wdata[d]  = wd;
    exp_q.push_back(exp_rsp);
    @(posedge clk);
    @(negedge clk);
    acc_cyc      = cyc;
    req_valid[d] = 1'b0;
    $display("issue dut%0d we=%0d size=%0d signed=%0d addr=%h wdata=%h", d, we, sz, sg, a, wd);
  endtask

  // Wait (bounded) for the response, check latency from accept and data.
  task automatic wait_rsp(input int d, input int lat, input string tag);
    bit got = 1'b0;
    logic [31:0] exp;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      if (rsp_valid[d]) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_seen"}, 32'(got), 32'd1);
    if (got) begin
      exp = exp_q.pop_front();
      chk({tag, "_lat"}, 32'(cyc - acc_cyc + 1), 32'(lat));
      chk({tag, "_data"}, rsp_rdata[d], exp);
      $display("rsp dut%0d %s rdata=%h latency=T+%0d", d, tag, rsp_rdata[d], cyc - acc_cyc + 1);
    end
  endtask

  initial begin
    bit got;
    logic [31:0] exp;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'd0;
      req_signed[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", 32'(req_ready[d]), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata[d], 32'd0);
      chk("rst_ai", 32'(obs_ai[d]), 32'd0);
      chk("rst_vi", obs_vi[d], 32'd0);
      chk("rst_bmsk", 32'(obs_bmsk[d]), 32'd0);
      chk("rst_we", 32'(obs_we[d]), 32'd0);
    end

    // Aligned word store and load.
    issue(0, 1, 2'd2, 0, 17'h00010, 32'hDEADBEEF, 32'd0);
    chk("sw_ai", 32'(obs_ai[0]), 32'h4);
    chk("sw_bmsk", 32'(obs_bmsk[0]), 32'hF);
    chk("sw_we", 32'(obs_we[0]), 32'd1);
    chk("sw_vi", obs_vi[0], 32'hDEADBEEF);
    @(negedge clk);
    chk("sw_we_after", 32'(obs_we[0]), 32'd0);
    chk("sw_bmsk_after", 32'(obs_bmsk[0]), 32'd0);
    wait_rsp(0, 3, "sw");
    issue(0, 0, 2'd2, 0, 17'h00010, 32'd0, 32'hDEADBEEF);
    chk("lw_ai", 32'(obs_ai[0]), 32'h4);
    chk("lw_bmsk", 32'(obs_bmsk[0]), 32'hF);
    chk("lw_we", 32'(obs_we[0]), 32'd0);
    wait_rsp(0, 4, "lw");

    // Byte lanes and extension.
    issue(0, 1, 2'd0, 0, 17'h00013, 32'h00000080, 32'd0);
    chk("sb_bmsk", 32'(obs_bmsk[0]), 32'h8);
    chk("sb_vi_top", 32'(obs_vi[0][31:24]), 32'h80);
    wait_rsp(0, 3, "sb");
    issue(0, 0, 2'd0, 1, 17'h00013, 32'd0, 32'hFFFFFF80);
    wait_rsp(0, 4, "lb_signed");
    issue(0, 0, 2'd0, 0, 17'h00013, 32'd0, 32'h00000080);
    wait_rsp(0, 4, "lb_unsigned");
    issue(0, 0, 2'd1, 1, 17'h00012, 32'd0, 32'hFFFF80AD);
    wait_rsp(0, 4, "lh_signed");
    issue(0, 0, 2'd3, 1, 17'h00010, 32'd0, 32'h80ADBEEF);
    wait_rsp(0, 4, "lw_size3");

    // Split half.
    issue(0, 1, 2'd1, 0, 17'h00007, 32'h00001234, 32'd0);
    chk("sh_b1_ai", 32'(obs_ai[0]), 32'h1);
    chk("sh_b1_bmsk", 32'(obs_bmsk[0]), 32'h8);
    chk("sh_b1_vi", 32'(obs_vi[0][31:24]), 32'h34);
    @(negedge clk);
    chk("sh_b2_ai", 32'(obs_ai[0]), 32'h2);
    chk("sh_b2_bmsk", 32'(obs_bmsk[0]), 32'h1);
    chk("sh_b2_vi", 32'(obs_vi[0][7:0]), 32'h12);
    chk("sh_b2_we", 32'(obs_we[0]), 32'd1);
    wait_rsp(0, 4, "sh_split");
    issue(0, 0, 2'd1, 0, 17'h00007, 32'd0, 32'h00001234);
    wait_rsp(0, 5, "lh_split");

    // Wrap from the last word to word 0.
    issue(0, 1, 2'd2, 0, 17'h1FFFE, 32'hA1B2C3D4, 32'd0);
    chk("wr_b1_ai", 32'(obs_ai[0]), 32'h7FFF);
    chk("wr_b1_bmsk", 32'(obs_bmsk[0]), 32'hC);
    chk("wr_b1_vi", obs_vi[0], 32'hC3D40000);
    @(negedge clk);
    chk("wr_b2_ai", 32'(obs_ai[0]), 32'h0);
    chk("wr_b2_bmsk", 32'(obs_bmsk[0]), 32'h3);
    chk("wr_b2_vi", obs_vi[0], 32'h0000A1B2);
    wait_rsp(0, 4, "sw_wrap");
    issue(0, 0, 2'd2, 0, 17'h1FFFE, 32'd0, 32'hA1B2C3D4);
    wait_rsp(0, 5, "lw_wrap");
    issue(0, 0, 2'd1, 1, 17'h1FFFF, 32'd0, 32'hFFFFB2C3);
    wait_rsp(0, 5, "lh_wrap_signed");

    // RD_LAT=2 instance: store, then back-to-back with req_valid held.
    issue(1, 1, 2'd2, 0, 17'h00040, 32'h11223344, 32'd0);
    wait_rsp(1, 3, "sw_lat2");
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_size[1] = 2'd2;
    req_signed[1] = 1'b0; req_addr[1] = 17'h00040; req_wdata[1] = 32'd0;
    exp_q.push_back(32'h11223344);
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    req_we[1] = 1'b1; req_addr[1] = 17'h00044; req_wdata[1] = 32'h55667788;
    $display("issue dut1 back-to-back load 00040 then store 00044");
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid[1]) begin
        got = 1'b1;
        break;
      end
      chk("b2b_busy_ready", 32'(req_ready[1]), 32'd0);
      @(negedge clk);
    end
    chk("b2b_seen", 32'(got), 32'd1);
    if (got) begin
      exp = exp_q.pop_front();
      chk("b2b_lat", 32'(cyc - acc_cyc + 1), 32'd5);
      chk("b2b_data", rsp_rdata[1], exp);
      chk("b2b_ready_at_rsp", 32'(req_ready[1]), 32'd1);
      $display("rsp dut1 b2b rdata=%h latency=T+%0d", rsp_rdata[1], cyc - acc_cyc + 1);
    end
    exp_q.push_back(32'd0);
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    req_valid[1] = 1'b0;
    chk("b2b_st_ai", 32'(obs_ai[1]), 32'h11);
    chk("b2b_st_bmsk", 32'(obs_bmsk[1]), 32'hF);
    chk("b2b_st_we", 32'(obs_we[1]), 32'd1);
    chk("b2b_st_vi", obs_vi[1], 32'h55667788);
    wait_rsp(1, 3, "b2b_store");
    issue(1, 0, 2'd2, 0, 17'h00044, 32'd0, 32'h55667788);
    wait_rsp(1, 5, "lw_lat2");
    issue(1, 0, 2'd2, 0, 17'h00042, 32'd0, 32'h77881122);
    wait_rsp(1, 6, "lw_split_lat2");

    // Reset during beat 2 of a split store.
    issue(0, 1, 2'd2, 0, 17'h00024, 32'h55555555, 32'd0);
    wait_rsp(0, 3, "pre_a");
    issue(0, 1, 2'd2, 0, 17'h00028, 32'h55555555, 32'd0);
    wait_rsp(0, 3, "pre_b");
    issue(0, 1, 2'd1, 0, 17'h00027, 32'h0000BEEF, 32'd0);
    @(negedge clk);
    chk("rst_mid_b2_we", 32'(obs_we[0]), 32'd1);
    chk("rst_mid_b2_ai", 32'(obs_ai[0]), 32'hA);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we_drop", 32'(obs_we[0]), 32'd0);
    chk("rst_mid_bmsk_drop", 32'(obs_bmsk[0]), 32'd0);
    exp_q.delete();
    $display("reset asserted during split store beat 2");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rst_mid_no_rsp", 32'(rsp_valid[0]), 32'd0);
    end
    chk("rst_mid_ready", 32'(req_ready[0]), 32'd1);
    issue(0, 0, 2'd0, 0, 17'h00027, 32'd0, 32'h000000EF);
    wait_rsp(0, 4, "partial_b1_kept");
    issue(0, 0, 2'd0, 0, 17'h00028, 32'd0, 32'h00000055);
    wait_rsp(0, 4, "partial_b2_absent");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
